// File: rtl/adc_align_seq_pkg.sv
// adc_align_pkg: shared types and constants for the ADC link-training sequencer.
//   state_e : sequencer FSM states
//   trk_t   : per-line stable-window tracker state, sized for the widest
//             supported tap range (64 taps -> 6-bit tap, 7-bit length)
package adc_align_pkg;

  localparam int NLINES     = 9;
  localparam int FRAME_LINE = 8;
  localparam int TAP_W_MAX  = 6;
  localparam int LEN_W_MAX  = 7;

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    RST1  = 4'd1,
    CAL   = 4'd2,
    SRST  = 4'd3,
    CHECK = 4'd4,
    EVAL  = 4'd5,
    STEP  = 4'd6,
    RST2  = 4'd7,
    APPLY = 4'd8,
    BSLIP = 4'd9,
    EVALF = 4'd10,
    DONE  = 4'd11,
    FAIL  = 4'd12
  } state_e;

  typedef struct packed {
    logic [TAP_W_MAX-1:0] cur_start;
    logic [LEN_W_MAX-1:0] cur_len;
    logic [TAP_W_MAX-1:0] best_start;
    logic [LEN_W_MAX-1:0] best_len;
  } trk_t;

endpackage

// File: rtl/adc_align_seq_if.sv
// adc_align_seq_if: bundles the CSR handshake and the receiver control/status
// signals of the alignment sequencer.
//   start       CSR -> seq   single-cycle alignment request
//   ins_cnt     rx  -> seq   per-line instability counters, 8 bits per line
//   dly_rst/dly_cal/dly_inc  IODELAY reset/calibrate/increment pulses
//   serdes_rst  ISERDES reset pulse
//   chk_run     check window for the instability counters
//   bs_enb      coherent bitslip enable
//   busy/done/fail/fail_mask/tap_out  status back to the CSR
// modport master = sequencer side, modport slave = receiver/CSR side.
interface adc_align_seq_if #(
  parameter int TAP_W = 6
);
  import adc_align_pkg::*;

  logic                     start;
  logic [8*NLINES-1:0]      ins_cnt;
  logic                     dly_rst;
  logic                     dly_cal;
  logic [NLINES-1:0]        dly_inc;
  logic                     serdes_rst;
  logic                     chk_run;
  logic                     bs_enb;
  logic                     busy;
  logic                     done;
  logic                     fail;
  logic [NLINES-1:0]        fail_mask;
  logic [NLINES*TAP_W-1:0]  tap_out;

  modport master (
    input  start, ins_cnt,
    output dly_rst, dly_cal, dly_inc, serdes_rst, chk_run, bs_enb,
    output busy, done, fail, fail_mask, tap_out
  );

  modport slave (
    output start, ins_cnt,
    input  dly_rst, dly_cal, dly_inc, serdes_rst, chk_run, bs_enb,
    input  busy, done, fail, fail_mask, tap_out
  );

endinterface

// File: rtl/adc_align_seq_win_track.sv
// align_win_track: tracks the current and the widest stable tap window of one
// serial line while the shared delay is swept.
//   clk, rst    clock and synchronous active-high reset
//   clr         clears all tracker state (new alignment attempt)
//   eval        one-cycle strobe: classify tap 'tap' using 'stable'
//   stable      this line's instability count was within threshold
//   tap         tap currently applied to all lines
//   best_start  first tap of the widest window seen so far
//   best_len    length of that window, saturating at NTAPS
module align_win_track
  import adc_align_pkg::*;
#(
  parameter int NTAPS = 32,
  parameter int TAP_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             eval,
  input  logic             stable,
  input  logic [TAP_W-1:0] tap,
  output logic [TAP_W-1:0] best_start,
  output logic [TAP_W:0]   best_len
);

  localparam logic [LEN_W_MAX-1:0] LEN_SAT = LEN_W_MAX'(NTAPS);

  trk_t trk_q, trk_d;

  // Next tracker state: extend or break the current run, promote on strict growth.
  always_comb begin
    trk_d = trk_q;
    if (clr) begin
      trk_d = '0;
    end else if (eval) begin
      if (stable) begin
        if (trk_q.cur_len == LEN_SAT) begin
          trk_d.cur_len = trk_q.cur_len;
        end else begin
          trk_d.cur_len = trk_q.cur_len + 7'd1;
        end
        if (trk_q.cur_len == 7'd0) begin
          trk_d.cur_start = TAP_W_MAX'(tap);
        end else begin
          trk_d.cur_start = trk_q.cur_start;
        end
        // Strict compare: an equal-length later window never replaces the earlier one.
        if (trk_d.cur_len > trk_q.best_len) begin
          trk_d.best_start = trk_d.cur_start;
          trk_d.best_len   = trk_d.cur_len;
        end else begin
          trk_d.best_start = trk_q.best_start;
          trk_d.best_len   = trk_q.best_len;
        end
      end else begin
        trk_d.cur_len = '0;
      end
    end else begin
      trk_d = trk_q;
    end
  end

  // Tracker state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      trk_q <= '0;
    end else begin
      trk_q <= trk_d;
    end
  end

  assign best_start = trk_q.best_start[TAP_W-1:0];
  assign best_len   = trk_q.best_len[TAP_W:0];

endmodule

// File: rtl/adc_align_seq.sv
// adc_align_seq: automatic link-training sequencer for one 9-line ADC receiver
// (8 data lines + frame line 8). Resets/calibrates the IODELAYs, sweeps the
// shared tap range measuring instability per tap, centres every line in its
// widest stable window, runs coherent bitslip and reports done/fail.
//   CLK   receiver data clock
//   RST   synchronous active-high reset, aborts any sequence
//   bus   adc_align_seq_if.master: start/ins_cnt in, receiver commands and
//         busy/done/fail/fail_mask/tap_out out (all outputs registered)
// Optional build macro ADC_ALIGN_RETRY_EN: a failed attempt is retried up to
// two more times before FAIL is reported.
module adc_align_seq
  import adc_align_pkg::*;
#(
  parameter int NTAPS   = 32,
  parameter int TAP_W   = 6,
  parameter int SETTLE  = 16,
  parameter int WIN     = 1024,
  parameter int INS_THR = 0,
  parameter int MIN_WIN = 4,
  parameter int BS_CYC  = 64
) (
  input logic               CLK,
  input logic               RST,
  adc_align_seq_if.master   bus
);

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] SETTLE_C   = CNT_W'(SETTLE);
  localparam logic [CNT_W-1:0] WIN_LAST_C = CNT_W'(WIN - 1);
  localparam logic [CNT_W-1:0] WIN_END_C  = CNT_W'(WIN + 1);
  localparam logic [CNT_W-1:0] BS_LAST_C  = CNT_W'(BS_CYC - 1);
  localparam logic [TAP_W-1:0] TAP_LAST_C = TAP_W'(NTAPS - 1);
  localparam logic [TAP_W:0]   MIN_WIN_C  = (TAP_W+1)'(MIN_WIN);
  localparam logic [7:0]       INS_THR_C  = 8'(INS_THR);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [TAP_W-1:0]        tap_q, tap_d;
  logic [TAP_W:0]          step_q, step_d;
  logic                    dly_rst_q, dly_rst_d;
  logic                    dly_cal_q, dly_cal_d;
  logic [NLINES-1:0]       dly_inc_q, dly_inc_d;
  logic                    serdes_rst_q, serdes_rst_d;
  logic                    chk_run_q, chk_run_d;
  logic                    bs_enb_q, bs_enb_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    fail_q, fail_d;
  logic [NLINES-1:0]       fail_mask_q, fail_mask_d;
  logic [NLINES*TAP_W-1:0] tap_out_q, tap_out_d;
`ifdef ADC_ALIGN_RETRY_EN
  logic [1:0]              retries_q, retries_d;
`endif

  logic                    trk_clr_s;
  logic                    trk_eval_s;
  logic [NLINES-1:0]       stable_s;
  logic [NLINES-1:0]       mask_s;
  logic [NLINES-1:0]       fail_line_s;
  logic [TAP_W:0]          mask_step_s;
  logic [NLINES*TAP_W-1:0] tap_pack_s;
  logic [TAP_W-1:0]        best_start_s [NLINES];
  logic [TAP_W:0]          best_len_s   [NLINES];
  logic [TAP_W-1:0]        target_s     [NLINES];

  assign trk_eval_s = (state_q == EVAL);
  // APPLY decides the next increment mask for the step about to be issued.
  assign mask_step_s = (state_q == APPLY) ? (step_q + (TAP_W+1)'(1)) : '0;

  for (genvar g = 0; g < NLINES; g++) begin : g_line
    assign stable_s[g] = (bus.ins_cnt[8*g +: 8] <= INS_THR_C);

    align_win_track #(
      .NTAPS (NTAPS),
      .TAP_W (TAP_W)
    ) u_trk (
      .clk        (CLK),
      .rst        (RST),
      .clr        (trk_clr_s),
      .eval       (trk_eval_s),
      .stable     (stable_s[g]),
      .tap        (tap_q),
      .best_start (best_start_s[g]),
      .best_len   (best_len_s[g])
    );

    // Window centre; a line that never saw a stable tap keeps target 0.
    assign target_s[g]    = TAP_W'({1'b0, best_start_s[g]} + (best_len_s[g] >> 1));
    assign mask_s[g]      = (mask_step_s < {1'b0, target_s[g]});
    assign fail_line_s[g] = (best_len_s[g] < MIN_WIN_C);
    assign tap_pack_s[TAP_W*g +: TAP_W] = target_s[g];
  end

  // Sequencer next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + 16'd1;
    tap_d        = tap_q;
    step_d       = step_q;
    dly_rst_d    = 1'b0;
    dly_cal_d    = 1'b0;
    dly_inc_d    = '0;
    serdes_rst_d = 1'b0;
    chk_run_d    = chk_run_q;
    bs_enb_d     = bs_enb_q;
    busy_d       = busy_q;
    done_d       = done_q;
    fail_d       = fail_q;
    fail_mask_d  = fail_mask_q;
    tap_out_d    = tap_out_q;
    trk_clr_s    = 1'b0;
`ifdef ADC_ALIGN_RETRY_EN
    retries_d    = retries_q;
`endif
    case (state_q)
      IDLE, DONE, FAIL: begin
        cnt_d = '0;
        if (bus.start) begin
          state_d     = RST1;
          dly_rst_d   = 1'b1;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          fail_d      = 1'b0;
          fail_mask_d = '0;
          tap_out_d   = '0;
          trk_clr_s   = 1'b1;
`ifdef ADC_ALIGN_RETRY_EN
          retries_d   = 2'd0;
`endif
        end else begin
          state_d = state_q;
        end
      end
      RST1: begin
        if (cnt_q == SETTLE_C) begin
          state_d   = CAL;
          cnt_d     = '0;
          dly_cal_d = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      CAL: begin
        if (cnt_q == SETTLE_C) begin
          state_d      = SRST;
          cnt_d        = '0;
          serdes_rst_d = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      SRST: begin
        if (cnt_q == SETTLE_C) begin
          state_d   = CHECK;
          cnt_d     = '0;
          tap_d     = '0;
          chk_run_d = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      CHECK: begin
        // chk_run covers cnt 0..WIN-1, then two quiet cycles let the counters settle.
        if (cnt_q == WIN_END_C) begin
          state_d = EVAL;
          cnt_d   = '0;
        end else if (cnt_q == WIN_LAST_C) begin
          chk_run_d = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      EVAL: begin
        cnt_d = '0;
        if (tap_q == TAP_LAST_C) begin
          state_d   = RST2;
          dly_rst_d = 1'b1;
        end else begin
          state_d   = STEP;
          dly_inc_d = '1;
        end
      end
      STEP: begin
        if (cnt_q == SETTLE_C) begin
          state_d   = CHECK;
          cnt_d     = '0;
          tap_d     = tap_q + TAP_W'(1);
          chk_run_d = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      RST2, APPLY: begin
        if (cnt_q == SETTLE_C) begin
          cnt_d  = '0;
          step_d = mask_step_s;
          if (|mask_s) begin
            state_d   = APPLY;
            dly_inc_d = mask_s;
          end else begin
            state_d  = BSLIP;
            bs_enb_d = 1'b1;
          end
        end else begin
          state_d = state_q;
        end
      end
      BSLIP: begin
        if (cnt_q == BS_LAST_C) begin
          state_d  = EVALF;
          cnt_d    = '0;
          bs_enb_d = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      EVALF: begin
        cnt_d = '0;
        if (|fail_line_s) begin
`ifdef ADC_ALIGN_RETRY_EN
          if (retries_q < 2'd2) begin
            retries_d = retries_q + 2'd1;
            state_d   = RST1;
            dly_rst_d = 1'b1;
            trk_clr_s = 1'b1;
          end else begin
            state_d     = FAIL;
            fail_d      = 1'b1;
            done_d      = 1'b0;
            busy_d      = 1'b0;
            fail_mask_d = fail_line_s;
            tap_out_d   = tap_pack_s;
          end
`else
          state_d     = FAIL;
          fail_d      = 1'b1;
          done_d      = 1'b0;
          busy_d      = 1'b0;
          fail_mask_d = fail_line_s;
          tap_out_d   = tap_pack_s;
`endif
        end else begin
          state_d     = DONE;
          done_d      = 1'b1;
          fail_d      = 1'b0;
          busy_d      = 1'b0;
          fail_mask_d = fail_line_s;
          tap_out_d   = tap_pack_s;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Sequencer state and output registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      tap_q        <= '0;
      step_q       <= '0;
      dly_rst_q    <= 1'b0;
      dly_cal_q    <= 1'b0;
      dly_inc_q    <= '0;
      serdes_rst_q <= 1'b0;
      chk_run_q    <= 1'b0;
      bs_enb_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
      fail_mask_q  <= '0;
      tap_out_q    <= '0;
`ifdef ADC_ALIGN_RETRY_EN
      retries_q    <= 2'd0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tap_q        <= tap_d;
      step_q       <= step_d;
      dly_rst_q    <= dly_rst_d;
      dly_cal_q    <= dly_cal_d;
      dly_inc_q    <= dly_inc_d;
      serdes_rst_q <= serdes_rst_d;
      chk_run_q    <= chk_run_d;
      bs_enb_q     <= bs_enb_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      fail_q       <= fail_d;
      fail_mask_q  <= fail_mask_d;
      tap_out_q    <= tap_out_d;
`ifdef ADC_ALIGN_RETRY_EN
      retries_q    <= retries_d;
`endif
    end
  end

  assign bus.dly_rst    = dly_rst_q;
  assign bus.dly_cal    = dly_cal_q;
  assign bus.dly_inc    = dly_inc_q;
  assign bus.serdes_rst = serdes_rst_q;
  assign bus.chk_run    = chk_run_q;
  assign bus.bs_enb     = bs_enb_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.fail       = fail_q;
  assign bus.fail_mask  = fail_mask_q;
  assign bus.tap_out    = tap_out_q;

endmodule

// File: tb/tb_adc_align_seq.sv
// tb_adc_align_seq: receiver model + window-search reference model for the
// ADC alignment sequencer. WIN is shortened to keep the run brief.
module tb_adc_align_seq;
  import adc_align_pkg::*;

  localparam int NTAPS   = 32;
  localparam int TAP_W   = 6;
  localparam int SETTLE  = 16;
  localparam int WIN     = 48;
  localparam int INS_THR = 0;
  localparam int MIN_WIN = 4;
  localparam int BS_CYC  = 64;
  localparam int RUN_LIM = 15000;
`ifdef ADC_ALIGN_RETRY_EN
  localparam int FAIL_ATTEMPTS = 3;
`else
  localparam int FAIL_ATTEMPTS = 1;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  adc_align_seq_if #(.TAP_W(TAP_W)) bus ();

  adc_align_seq #(
    .NTAPS(NTAPS), .TAP_W(TAP_W), .SETTLE(SETTLE), .WIN(WIN),
    .INS_THR(INS_THR), .MIN_WIN(MIN_WIN), .BS_CYC(BS_CYC)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  int n_chk = 0;
  int n_fail = 0;

  bit         stab    [NLINES][NTAPS];
  logic [7:0] bad_val [NLINES];
  int line_tap [NLINES];
  int n_apply  [NLINES];
  int n_scan_inc = 0;
  int n_dly_rst  = 0;
  int n_rst1     = 0;
  int phase      = 0;   // 0: before scan, 1: tap sweep, 2: centring
  int cyc        = 0;
  int last_cmd   = -1;
  int chk_len    = 0;
  bit chk_prev   = 1'b0;

  int exp_tgt [NLINES];
  int exp_len [NLINES];
  logic [NLINES-1:0] exp_mask;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Receiver model and per-cycle protocol compare.
  always @(negedge clk) begin
    int kinds;
    cyc++;
    if (rst) begin
      phase    = 0;
      last_cmd = -1;
      chk_len  = 0;
      chk_prev = 1'b0;
    end else begin
      kinds = int'(bus.dly_rst) + int'(bus.dly_cal) + int'(bus.serdes_rst) + int'(|bus.dly_inc);
      check("done_fail_excl", bus.done & bus.fail, 0);
      if (!bus.busy)
        check("idle_quiet", {kinds != 0, bus.chk_run, bus.bs_enb}, 0);
      if (kinds != 0) begin
        check("one_cmd", kinds, 1);
        check("cmd_quiet_chk", {bus.chk_run, bus.bs_enb}, 0);
        if (last_cmd >= 0)
          check("settle_gap", (cyc - last_cmd) > SETTLE, 1);
        last_cmd = cyc;
      end
      if (bus.chk_run) begin
        chk_len++;
      end else if (chk_prev) begin
        check("chk_len", chk_len, WIN);
        chk_len = 0;
      end
      chk_prev = bus.chk_run;
      if (bus.serdes_rst) begin
        phase      = 1;
        n_scan_inc = 0;
      end
      if (bus.dly_rst) begin
        n_dly_rst++;
        for (int i = 0; i < NLINES; i++) line_tap[i] = 0;
        if (phase == 1) begin
          phase = 2;
          for (int i = 0; i < NLINES; i++) n_apply[i] = 0;
        end else begin
          n_rst1++;
        end
      end
      if (|bus.dly_inc) begin
        if (phase == 1) begin
          check("scan_inc_mask", bus.dly_inc, 9'h1FF);
          n_scan_inc++;
        end
        for (int i = 0; i < NLINES; i++)
          if (bus.dly_inc[i]) begin
            line_tap[i]++;
            if (phase == 2) n_apply[i]++;
          end
      end
    end
    for (int i = 0; i < NLINES; i++)
      bus.ins_cnt[8*i +: 8] = (line_tap[i] < NTAPS && stab[i][line_tap[i]]) ? 8'd0 : bad_val[i];
  end

  task automatic clr_pat();
    for (int i = 0; i < NLINES; i++) begin
      bad_val[i] = 8'd50;
      for (int t = 0; t < NTAPS; t++) stab[i][t] = 1'b0;
    end
  endtask

  task automatic set_win(input int ln, input int lo, input int hi);
    for (int t = lo; t <= hi && t < NTAPS; t++) stab[ln][t] = 1'b1;
  endtask

  // Reference: longest maximal run of stable taps, earliest start on ties.
  task automatic model();
    exp_mask = '0;
    for (int i = 0; i < NLINES; i++) begin
      int bs = 0;
      int bl = 0;
      for (int s = 0; s < NTAPS; s++) begin
        int len = 0;
        while (s + len < NTAPS && stab[i][s + len]) len++;
        if (len > bl) begin bl = len; bs = s; end
      end
      exp_len[i] = bl;
      exp_tgt[i] = bs + bl / 2;
      exp_mask[i] = (bl < MIN_WIN);
    end
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_end(input string name);
    int k = 0;
    while (!(bus.done || bus.fail) && k < RUN_LIM) begin
      @(negedge clk);
      k++;
    end
    check({name, "_timeout"}, k < RUN_LIM, 1);
  endtask

  task automatic check_results(input string name, input int base_rst, input int base_rst1);
    int att;
    model();
    att = (exp_mask != '0) ? FAIL_ATTEMPTS : 1;
    check({name, "_busy"}, bus.busy, 0);
    check({name, "_done"}, bus.done, exp_mask == '0);
    check({name, "_fail"}, bus.fail, exp_mask != '0);
    check({name, "_fail_mask"}, bus.fail_mask, exp_mask);
    check({name, "_scan_incs"}, n_scan_inc, NTAPS - 1);
    check({name, "_dly_rst_cnt"}, n_dly_rst - base_rst, 2 * att);
    check({name, "_rst1_cnt"}, n_rst1 - base_rst1, att);
    for (int i = 0; i < NLINES; i++) begin
      check($sformatf("%s_tap_out%0d", name, i), bus.tap_out[TAP_W*i +: TAP_W], exp_tgt[i]);
      check($sformatf("%s_rx_tap%0d", name, i), line_tap[i], exp_tgt[i]);
      check($sformatf("%s_apply%0d", name, i), n_apply[i], exp_tgt[i]);
    end
  endtask

  initial begin
    int b0, b1, k;
    rst = 1'b1;
    bus.start = 1'b0;
    clr_pat();
    for (int i = 0; i < NLINES; i++) begin line_tap[i] = 0; n_apply[i] = 0; end
    repeat (3) @(negedge clk);
    check("rst_pulses", {bus.dly_rst, bus.dly_cal, bus.serdes_rst, bus.dly_inc}, 0);
    check("rst_status", {bus.busy, bus.done, bus.fail, bus.chk_run, bus.bs_enb}, 0);
    check("rst_fail_mask", bus.fail_mask, 0);
    check("rst_tap_out", bus.tap_out, 0);
    rst = 1'b0;
    @(negedge clk);

    // All lines stable at taps 10..19.
    clr_pat();
    for (int i = 0; i < NLINES; i++) set_win(i, 10, 19);
    b0 = n_dly_rst; b1 = n_rst1;
    do_start();
    wait_end("s1");
    check_results("s1", b0, b1);
    check("s1_scan_incs_lit", n_scan_inc, 31);
    check("s1_tap0_lit", bus.tap_out[5:0], 15);
    check("s1_tap8_lit", bus.tap_out[53:48], 15);
    check("s1_done_lit", {bus.done, bus.fail}, 2'b10);

    // Line 3 two windows (wider one later), start re-pulsed mid-scan.
    clr_pat();
    for (int i = 0; i < NLINES; i++) set_win(i, 8, 12);
    for (int t = 0; t < NTAPS; t++) stab[3][t] = 1'b0;
    set_win(3, 2, 5);
    set_win(3, 20, 27);
    b0 = n_dly_rst; b1 = n_rst1;
    do_start();
    repeat (300) @(negedge clk);
    do_start();
    wait_end("s2");
    check_results("s2", b0, b1);
    check("s2_line3_lit", bus.tap_out[23:18], 24);
    check("s2_line3_apply_lit", n_apply[3], 24);
    check("s2_line0_lit", bus.tap_out[5:0], 10);

    // Frame line never stable.
    clr_pat();
    for (int i = 0; i < 8; i++) set_win(i, 10, 19);
    b0 = n_dly_rst; b1 = n_rst1;
    do_start();
    wait_end("s3");
    check_results("s3", b0, b1);
    check("s3_fail_mask_lit", bus.fail_mask, 9'h100);
    check("s3_status_lit", {bus.done, bus.fail}, 2'b01);
    check("s3_rst1_lit", n_rst1 - b1, FAIL_ATTEMPTS);

    // Two equal 6-tap windows on line 0: earlier one wins.
    clr_pat();
    for (int i = 1; i < NLINES; i++) set_win(i, 10, 19);
    set_win(0, 4, 9);
    set_win(0, 20, 25);
    b0 = n_dly_rst; b1 = n_rst1;
    do_start();
    wait_end("s4");
    check_results("s4", b0, b1);
    check("s4_line0_lit", bus.tap_out[5:0], 7);

    // Reset while checking tap 5, then restart.
    clr_pat();
    for (int i = 0; i < NLINES; i++) set_win(i, 10, 19);
    do_start();
    k = 0;
    while (!(phase == 1 && line_tap[0] == 5 && bus.chk_run) && k < RUN_LIM) begin
      @(negedge clk);
      k++;
    end
    check("s5_reach_tap5", k < RUN_LIM, 1);
    rst = 1'b1;
    @(negedge clk);
    check("s5_abort_chk", {bus.chk_run, bus.bs_enb, bus.busy}, 0);
    check("s5_abort_pulses", {bus.dly_rst, bus.dly_cal, bus.serdes_rst, bus.dly_inc}, 0);
    check("s5_abort_status", {bus.done, bus.fail, bus.fail_mask, bus.tap_out}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    b0 = n_dly_rst; b1 = n_rst1;
    do_start();
    k = 0;
    while (!(bus.dly_rst || bus.dly_cal || bus.serdes_rst || (|bus.dly_inc)) && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("s5_first_cmd_seen", k < 100, 1);
    check("s5_first_cmd_rst", {bus.dly_rst, bus.dly_cal, bus.serdes_rst, bus.dly_inc}, 12'h800);
    wait_end("s5");
    check_results("s5", b0, b1);

    // Randomised windows with scattered stable taps and random counts.
    for (int r = 0; r < 3; r++) begin
      clr_pat();
      for (int i = 0; i < NLINES; i++) begin
        int lo;
        int len;
        lo  = $urandom_range(0, NTAPS - 1);
        len = $urandom_range(0, 12);
        if (len > 0) set_win(i, lo, lo + len - 1);
        for (int t = 0; t < NTAPS; t++)
          if ($urandom_range(0, 7) == 0) stab[i][t] = 1'b1;
        bad_val[i] = 8'($urandom_range(1, 255));
      end
      b0 = n_dly_rst; b1 = n_rst1;
      do_start();
      wait_end($sformatf("rnd%0d", r));
      check_results($sformatf("rnd%0d", r), b0, b1);
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/adc_align_seq.md
Name: adc_align_seq

Overview:
- Automatic link-training sequencer for one ADC receiver: 9 serial lines (8 data lines, line 8 = frame).
- Scans a shared IODELAY tap range and measures per-line instability at each tap using the receiver's check window.
- Finds the widest stable window per line and sets each line's delay to the window centre. It then enables coherent bitslip and reports done/fail.
- Sits between the channel CSR (start/status) and the receiver's IODELAY/SERDES/check controls, in place of manual WB-driven alignment.

Parameters:
- NTAPS, 32, number of taps scanned (2..64).
- TAP_W, 6, tap counter/result width.
- SETTLE, 16, CLK cycles waited after any delay/reset pulse.
- WIN, 1024, CLK cycles chk_run is held high per tap.
- INS_THR, 0, a tap is stable if its instability count is <= INS_THR.
- MIN_WIN, 4, minimum stable window length in taps; a shorter best window means failure.
- BS_CYC, 64, CLK cycles bs_enb is held high.

Ports:
- CLK  in  1  receiver data clock; the only clock.
- RST  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse; begins alignment; ignored unless in IDLE/DONE/FAIL.
- ins_cnt  in  72  per-line instability counters; line i at [8i+7:8i], saturating at 255.
- dly_rst  out  1  IODELAY reset pulse.
- dly_cal  out  1  IODELAY calibrate pulse.
- dly_inc  out  9  per-line IODELAY increment pulse mask.
- serdes_rst  out  1  ISERDES reset pulse.
- chk_run  out  1  check window; counters clear on its rise and count while it is high.
- bs_enb  out  1  coherent bitslip enable.
- busy  out  1  high from start until DONE/FAIL.
- done  out  1  sticky; alignment succeeded.
- fail  out  1  sticky; at least one line has best_len < MIN_WIN.
- fail_mask  out  9  lines that failed.
- tap_out  out  9*TAP_W  final tap per line; line i at [TAP_W*i+TAP_W-1:TAP_W*i].

Behaviour:
- Reset: all outputs are 0. State = IDLE. All per-line trackers are cleared.
- Pulses: dly_rst, dly_cal, serdes_rst and dly_inc are each exactly 1 CLK wide. Each pulse is followed by SETTLE cycles with no other command.
- FSM transitions:
  - IDLE/DONE/FAIL --start--> RST1. On this transition: clear done, fail, fail_mask, tap_out and trackers; set busy.
  - RST1: dly_rst, wait -> CAL.
  - CAL: dly_cal, wait -> SRST.
  - SRST: serdes_rst, wait -> CHECK; tap=0.
  - CHECK: chk_run=1 for WIN cycles, then 0. Wait 2 cycles for counters to settle -> EVAL.
  - EVAL (1 cycle): update every line i in parallel:
    - If stable: cur_len += 1; if cur_len was 0, cur_start=tap. If new cur_len > best_len, copy cur_start/cur_len to best.
    - If not stable: cur_len=0.
    - Ties keep the earlier window. If tap==NTAPS-1 -> RST2, else -> STEP.
  - STEP: dly_inc=9'h1FF, wait; tap+=1 -> CHECK.
  - RST2: dly_rst, wait -> APPLY; step=0. Compute target_i = best_start_i + (best_len_i>>1), truncated to TAP_W.
  - APPLY: each iteration pulses dly_inc[i] = (step < target_i) and waits SETTLE, then step+=1. Exit when the mask is 0 -> BSLIP. Lines with best_len=0 get target 0 and receive no increments.
  - BSLIP: bs_enb=1 for BS_CYC cycles, then 0 -> EVALF.
  - EVALF: set fail_mask[i] = best_len_i < MIN_WIN; load tap_out. If fail_mask != 0 -> FAIL, else -> DONE. Clear busy.
- A window that is still open at tap NTAPS-1 counts with its length at that tap; there is no wrap-around.
- start while busy is ignored.
- RST mid-operation aborts immediately. All outputs return to 0 on the next edge, including chk_run and bs_enb.
- cur_len and best_len saturate at NTAPS (TAP_W+1 bits).

Optional Feature:
- ADC_ALIGN_RETRY_EN
  - Defined: on a FAIL decision, if retries < 2, increment retries and re-enter RST1 instead of FAIL. busy stays high. retries clears on start.
  - Undefined: a single attempt; FAIL is final until the next start.

Decomposition:
- Package adc_align_pkg holds:
  - FSM state enum (IDLE, RST1, CAL, SRST, CHECK, EVAL, STEP, RST2, APPLY, BSLIP, EVALF, DONE, FAIL);
  - NLINES=9;
  - FRAME_LINE=8;
  - line tracker struct {cur_start, cur_len, best_start, best_len}.
- One natural sub-module, align_win_track: per-line window tracker with inputs clr, eval, stable, tap and outputs best_start, best_len. It is instantiated 9x.

Test Plan:
- NTAPS=32, model returns ins_cnt=0 for taps 10..19 on all lines, 50 elsewhere:
  - exactly 31 dly_inc=1FF pulses;
  - second dly_rst, then 15 single-line inc pulses per line;
  - tap_out all = 15, done=1, fail=0.
- Line 3 stable taps 2..5 and 20..27, others stable at 8..12:
  - line 3 gets tap 24, others get tap 10;
  - line 3 receives 24 APPLY pulses.
- Frame line never stable: fail=1, fail_mask=9'h100, done=0. With ADC_ALIGN_RETRY_EN, exactly 3 RST1 dly_rst pulses occur before fail.
- Two equal 6-tap windows on line 0 (taps 4..9 and 20..25): tap_out line 0 = 7 (earlier window wins).
- RST asserted during CHECK at tap 5:
  - next cycle chk_run=0, busy=0, all pulses 0;
  - after a later start, the scan restarts with dly_rst.
- start pulse while busy, plus window timing:
  - no effect;
  - chk_run high exactly WIN=1024 cycles per tap;
  - ≥SETTLE cycles between any two command pulses.
